// File: rtl/nyq_vca.sv
// Voltage-controlled amplifier after the Nyquist decimator: ADSR envelope stepped once per valid sample.
// Optional macro VCA_BYPASS_EN adds a parameter-controlled pass-through of the raw sample.
module nyq_vca #(
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_WIDTH  = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int ENV_WIDTH  = 23
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic signed [MEM_WIDTH-1:0] PAR_In_DI,
  input  logic signed [IN_WIDTH-1:0]  VCA_In_DI,
  input  logic                        VCA_Valid_DI,
  input  logic                        VCA_Gate_SI,
  output logic signed [OUT_WIDTH-1:0] VCA_Out_DO,
  output logic                        VCA_Valid_DO,
  output logic [2:0]                  VCA_State_DO,
  output logic [ENV_WIDTH-1:0]        VCA_Env_DO
);

  localparam int                   PW      = IN_WIDTH + ENV_WIDTH + 1;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = {ENV_WIDTH{1'b1}};
  localparam logic [ENV_WIDTH-1:0] ENV_0   = {ENV_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic [ENV_WIDTH-1:0] r_a, r_d, r_s, r_r;
  logic                 r_en;
  state_t               r_state, w_state_nxt;
  logic [ENV_WIDTH-1:0] r_env, w_env_nxt;
  logic signed [OUT_WIDTH-1:0] r_out, w_out_nxt, w_scaled;
  logic                 r_vld;
  logic [ENV_WIDTH:0]   w_sum_a, w_sum_sd;
  logic                 w_unused_par;

  assign w_unused_par = ^{1'b0, PAR_In_DI[MEM_WIDTH-1:ENV_WIDTH]};

`ifdef VCA_BYPASS_EN
  logic r_byp;
`endif

  // Parameter memory: writes land on the clock edge, so a coincident tick still sees old values
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_a  <= ENV_0;
      r_d  <= ENV_0;
      r_s  <= ENV_0;
      r_r  <= ENV_0;
      r_en <= 1'b0;
`ifdef VCA_BYPASS_EN
      r_byp <= 1'b0;
`endif
    end else if (WrEn_SI) begin
      case (Addr_DI)
        ADDR_WIDTH'(0): r_a  <= PAR_In_DI[ENV_WIDTH-1:0];
        ADDR_WIDTH'(1): r_d  <= PAR_In_DI[ENV_WIDTH-1:0];
        ADDR_WIDTH'(2): r_s  <= PAR_In_DI[ENV_WIDTH-1:0];
        ADDR_WIDTH'(3): r_r  <= PAR_In_DI[ENV_WIDTH-1:0];
        ADDR_WIDTH'(4): r_en <= PAR_In_DI[0];
`ifdef VCA_BYPASS_EN
        ADDR_WIDTH'(5): r_byp <= PAR_In_DI[0];
`endif
        default: ;
      endcase
    end
  end

  assign w_sum_a  = {1'b0, r_env} + {1'b0, r_a};
  assign w_sum_sd = {1'b0, r_s} + {1'b0, r_d};

  // Envelope state register
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= ST_IDLE;
      r_env   <= ENV_0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  // ADSR next-state; gate is only looked at on ticks
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (!r_en) begin
      w_state_nxt = ST_IDLE;
      w_env_nxt   = ENV_0;
    end else if (VCA_Valid_DI) begin
      case (r_state)
        ST_IDLE: begin
          w_env_nxt = ENV_0;
          if (VCA_Gate_SI) w_state_nxt = ST_ATTACK;
          else             w_state_nxt = ST_IDLE;
        end
        ST_ATTACK: begin
          if (!VCA_Gate_SI) begin
            w_state_nxt = ST_RELEASE;
          end else if (w_sum_a >= {1'b0, ENV_MAX}) begin
            w_env_nxt   = ENV_MAX;
            w_state_nxt = ST_DECAY;
          end else begin
            w_env_nxt = w_sum_a[ENV_WIDTH-1:0];
          end
        end
        ST_DECAY: begin
          if (!VCA_Gate_SI) begin
            w_state_nxt = ST_RELEASE;
          end else if ({1'b0, r_env} <= w_sum_sd) begin
            w_env_nxt   = r_s;
            w_state_nxt = ST_SUSTAIN;
          end else begin
            w_env_nxt = r_env - r_d;
          end
        end
        ST_SUSTAIN: begin
          w_env_nxt = r_s;
          if (!VCA_Gate_SI) w_state_nxt = ST_RELEASE;
          else              w_state_nxt = ST_SUSTAIN;
        end
        ST_RELEASE: begin
          // Retrigger resumes the attack from wherever the release had got to
          if (VCA_Gate_SI) begin
            w_state_nxt = ST_ATTACK;
          end else if (r_env <= r_r) begin
            w_env_nxt   = ENV_0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_env_nxt = r_env - r_r;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_env_nxt   = ENV_0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_env_nxt   = r_env;
    end
  end

  // Env is below 1.0, so the floor-shifted product always fits the output width
  assign w_scaled = OUT_WIDTH'((PW'(VCA_In_DI) * PW'($signed({1'b0, r_env}))) >>> ENV_WIDTH);

  // Output sample select
  always_comb begin
    w_out_nxt = w_scaled;
    if (!r_en) begin
      w_out_nxt = {OUT_WIDTH{1'b0}};
`ifdef VCA_BYPASS_EN
    end else if (r_byp) begin
      w_out_nxt = OUT_WIDTH'(VCA_In_DI);
`endif
    end else begin
      w_out_nxt = w_scaled;
    end
  end

  // Output register: sample held between ticks, strobe delayed by one clock
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_out <= {OUT_WIDTH{1'b0}};
      r_vld <= 1'b0;
    end else begin
      r_vld <= VCA_Valid_DI;
      if (VCA_Valid_DI) r_out <= w_out_nxt;
      else              r_out <= r_out;
    end
  end

  assign VCA_Out_DO   = r_out;
  assign VCA_Valid_DO = r_vld;
  assign VCA_State_DO = r_state;
  assign VCA_Env_DO   = r_env;

endmodule

// File: tb/tb_nyq_vca.sv
// Table-driven bench for nyq_vca: parameter writes and ticks with hand-computed envelope/output values.
module tb_nyq_vca;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [5:0]  addr = 6'd0;
  logic [23:0] pdata = 24'd0;
  logic [23:0] din = 24'd0;
  logic        vld = 1'b0;
  logic        gate = 1'b0;
  logic [23:0] dout;
  logic        dvld;
  logic [2:0]  st;
  logic [22:0] env;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [23:0] data;
    logic        gate;
    logic [23:0] din;
    logic [2:0]  st;
    logic [22:0] env;
    logic [23:0] dout;
  } vec_t;

  vec_t vecs[$];

`ifdef VCA_BYPASS_EN
  localparam logic [23:0] BYP_OUT = 24'h123456;
`else
  localparam logic [23:0] BYP_OUT = 24'h048D15;
`endif

  nyq_vca dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .WrEn_SI      (wr),
    .Addr_DI      (addr),
    .PAR_In_DI    (pdata),
    .VCA_In_DI    (din),
    .VCA_Valid_DI (vld),
    .VCA_Gate_SI  (gate),
    .VCA_Out_DO   (dout),
    .VCA_Valid_DO (dvld),
    .VCA_State_DO (st),
    .VCA_Env_DO   (env)
  );

  always #5 clk = ~clk;

  function automatic vec_t W(input logic [5:0] a, input logic [23:0] d);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.gate = 1'b0; v.din = 24'd0;
    v.st = 3'd0; v.env = 23'd0; v.dout = 24'd0;
    return v;
  endfunction

  function automatic vec_t T(input logic g, input logic [23:0] i, input logic [2:0] s,
                             input logic [22:0] e, input logic [23:0] o);
    vec_t v;
    v.wr = 1'b0; v.addr = 6'd0; v.data = 24'd0; v.gate = g; v.din = i;
    v.st = s; v.env = e; v.dout = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.wr) begin
      @(negedge clk); wr = 1'b1; addr = v.addr; pdata = v.data;
      @(negedge clk); wr = 1'b0;
    end else begin
      @(negedge clk); gate = v.gate; din = v.din; vld = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      chk($sformatf("v%0d valid", idx), 32'(dvld), 32'd1);
      chk($sformatf("v%0d state", idx), 32'(st), 32'(v.st));
      chk($sformatf("v%0d env", idx), 32'(env), 32'(v.env));
      chk($sformatf("v%0d out", idx), 32'(dout), 32'(v.dout));
      @(negedge clk); vld = 1'b0; din = 24'h5A5A5A;
      @(posedge clk); #1;
      chk($sformatf("v%0d valid_drop", idx), 32'(dvld), 32'd0);
      chk($sformatf("v%0d out_hold", idx), 32'(dout), 32'(v.dout));
      repeat (5) @(posedge clk);
    end
  endtask

  initial begin
    // Attack: A=0x100000 -> 7 steps then clamp to ENV_MAX
    vecs.push_back(W(6'd4, 24'd1));
    vecs.push_back(W(6'd0, 24'h100000));
    vecs.push_back(W(6'd1, 24'h080000));
    vecs.push_back(W(6'd2, 24'h400000));
    vecs.push_back(W(6'd3, 24'h200000));
    vecs.push_back(T(1'b1, 24'd0, 3'd1, 23'd0, 24'd0));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(T(1'b1, 24'd0, 3'd1, 23'(k * 32'h100000), 24'd0));
    vecs.push_back(T(1'b1, 24'd0, 3'd2, 23'h7FFFFF, 24'd0));
    // Decay; first step also checks 0x400000 * 0x7FFFFF
    vecs.push_back(T(1'b1, 24'h400000, 3'd2, 23'h77FFFF, 24'h3FFFFF));
    for (int k = 1; k <= 6; k++)
      vecs.push_back(T(1'b1, 24'd0, 3'd2, 23'(32'h77FFFF - k * 32'h080000), 24'd0));
    vecs.push_back(T(1'b1, 24'd0, 3'd3, 23'h400000, 24'd0));
    vecs.push_back(T(1'b1, 24'h800000, 3'd3, 23'h400000, 24'hC00000));
    // Sustain tracks S
    vecs.push_back(W(6'd2, 24'h300000));
    vecs.push_back(T(1'b1, 24'd0, 3'd3, 23'h300000, 24'd0));
    vecs.push_back(W(6'd2, 24'h400000));
    vecs.push_back(T(1'b1, 24'd0, 3'd3, 23'h400000, 24'd0));
    // Release to idle
    vecs.push_back(T(1'b0, 24'd0, 3'd4, 23'h400000, 24'd0));
    vecs.push_back(T(1'b0, 24'd0, 3'd4, 23'h200000, 24'd0));
    vecs.push_back(T(1'b0, 24'd0, 3'd0, 23'd0, 24'd0));
    vecs.push_back(T(1'b0, 24'd0, 3'd0, 23'd0, 24'd0));
    // Fast path back to sustain, then release and retrigger
    vecs.push_back(W(6'd0, 24'h7FFFFF));
    vecs.push_back(W(6'd1, 24'h7FFFFF));
    vecs.push_back(T(1'b1, 24'd0, 3'd1, 23'd0, 24'd0));
    vecs.push_back(T(1'b1, 24'd0, 3'd2, 23'h7FFFFF, 24'd0));
    vecs.push_back(T(1'b1, 24'd0, 3'd3, 23'h400000, 24'd0));
    vecs.push_back(T(1'b0, 24'd0, 3'd4, 23'h400000, 24'd0));
    vecs.push_back(T(1'b0, 24'd0, 3'd4, 23'h200000, 24'd0));
    vecs.push_back(W(6'd0, 24'h100000));
    vecs.push_back(T(1'b1, 24'd0, 3'd1, 23'h200000, 24'd0));
    // Bypass (scaled when the macro is absent: 0x123456 * 0.25)
    vecs.push_back(W(6'd5, 24'd1));
    vecs.push_back(T(1'b1, 24'h123456, 3'd1, 23'h300000, BYP_OUT));
    vecs.push_back(W(6'd5, 24'd0));
    // Enable cleared mid-attack
    vecs.push_back(W(6'd4, 24'd0));
    vecs.push_back(T(1'b1, 24'h400000, 3'd0, 23'd0, 24'd0));
    vecs.push_back(T(1'b1, 24'h400000, 3'd0, 23'd0, 24'd0));
    // Re-enable and get into decay for the reset test
    vecs.push_back(W(6'd4, 24'd1));
    vecs.push_back(W(6'd0, 24'h7FFFFF));
    vecs.push_back(W(6'd1, 24'h100000));
    vecs.push_back(T(1'b1, 24'd0, 3'd1, 23'd0, 24'd0));
    vecs.push_back(T(1'b1, 24'd0, 3'd2, 23'h7FFFFF, 24'd0));
    vecs.push_back(T(1'b1, 24'h400000, 3'd2, 23'h6FFFFF, 24'h3FFFFF));

    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("reset state", 32'(st), 32'd0);
    chk("reset env", 32'(env), 32'd0);
    chk("reset out", 32'(dout), 32'd0);
    chk("reset valid", 32'(dvld), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset mid-decay, away from any clock edge
    @(negedge clk); #2; rst_n = 1'b0; #1;
    n_vec++;
    chk("midrst state", 32'(st), 32'd0);
    chk("midrst env", 32'(env), 32'd0);
    chk("midrst out", 32'(dout), 32'd0);
    chk("midrst valid", 32'(dvld), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Parameters cleared: enable off, then A=0 holds attack at 0
    apply(T(1'b1, 24'h400000, 3'd0, 23'd0, 24'd0), 900);
    apply(W(6'd4, 24'd1), 901);
    apply(T(1'b1, 24'd0, 3'd1, 23'd0, 24'd0), 902);
    apply(T(1'b1, 24'h400000, 3'd1, 23'd0, 24'd0), 903);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
